// File: rtl/seg7_scan_if.sv
// Bundle between the display controller and seg7_scan. The host drives enable, load
// and digit data through the master modport; the driver returns seg, an and digit_idx.
interface seg7_scan_if #(
  parameter int P_DIGITS = 4
);
  localparam int IDXW = (P_DIGITS > 1) ? $clog2(P_DIGITS) : 1;

  logic                  en;
  logic                  load;
  logic [4*P_DIGITS-1:0] data;
  logic [P_DIGITS-1:0]   dp;
  logic [P_DIGITS-1:0]   blank;
  logic [7:0]            seg;
  logic [P_DIGITS-1:0]   an;
  logic [IDXW-1:0]       digit_idx;

  modport master (
    output en, load, data, dp, blank,
    input  seg, an, digit_idx
  );

  modport slave (
    input  en, load, data, dp, blank,
    output seg, an, digit_idx
  );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 7-segment scan driver. seg/an are registered one cycle behind scan state.
// No backpressure exists; defining SEG7_SCAN_LZB_EN enables leading-zero blanking.
module seg7_scan #(
  parameter int P_DIGITS     = 4,
  parameter int P_SCAN_DIV   = 50000,
  parameter int P_DEAD       = 1,
  parameter bit P_AN_ACT_LOW = 1'b1
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);
  localparam int IDXW = (P_DIGITS > 1) ? $clog2(P_DIGITS) : 1;
  localparam int PW   = $clog2(P_SCAN_DIV);
  localparam logic [P_DIGITS-1:0] AN_OFF = {P_DIGITS{P_AN_ACT_LOW}};

  logic [PW-1:0]         presc_q, presc_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [4*P_DIGITS-1:0] sh_data_q, sh_data_d;
  logic [P_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [P_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [7:0]            seg_q, seg_d;
  logic [P_DIGITS-1:0]   an_q, an_d;

  logic                  tc;
  logic                  in_dead;
  logic [P_DIGITS-1:0]   lz;
  logic [P_DIGITS-1:0]   an_act;
  logic [3:0]            sel_nib;
  logic                  sel_dp;
  logic                  sel_blank;
  logic                  sel_lz;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign tc = bus.en && (presc_q == PW'(P_SCAN_DIV - 1));

  generate
    if (P_DEAD == 0) begin : g_nodead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (presc_q < PW'(P_DEAD));
    end
  endgenerate

`ifdef SEG7_SCAN_LZB_EN
  // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
  logic lz_run;
  always_comb begin
    lz     = '0;
    lz_run = 1'b1;
    for (int i = P_DIGITS - 1; i >= 1; i--) begin
      lz_run = lz_run & (sh_data_q[4*i +: 4] == 4'h0);
      lz[i]  = lz_run;
    end
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    presc_d    = presc_q;
    idx_d      = idx_q;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    if (bus.en) begin
      presc_d = tc ? '0 : presc_q + PW'(1);
    end
    if (tc) begin
      idx_d = (idx_q == IDXW'(P_DIGITS - 1)) ? '0 : idx_q + IDXW'(1);
    end
    if (bus.load) begin
      sh_data_d  = bus.data;
      sh_dp_d    = bus.dp;
      sh_blank_d = bus.blank;
    end
  end

  always_comb begin
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b1;
    sel_lz    = 1'b0;
    an_act    = '0;
    for (int i = 0; i < P_DIGITS; i++) begin
      if (idx_q == IDXW'(i)) begin
        sel_nib   = sh_data_q[4*i +: 4];
        sel_dp    = sh_dp_q[i];
        sel_blank = sh_blank_q[i];
        sel_lz    = lz[i];
        an_act[i] = 1'b1;
      end
    end

    seg_d = 8'hFF;
    an_d  = AN_OFF;
    if (bus.en && !in_dead) begin
      an_d = P_AN_ACT_LOW ? ~an_act : an_act;
      if (sel_blank) begin
        seg_d = 8'hFF;
      end else if (sel_lz) begin
        seg_d = {~sel_dp, 7'h7F};
      end else begin
        seg_d = {~sel_dp, hex7(sel_nib)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      idx_q      <= '0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '1;
      seg_q      <= 8'hFF;
      an_q       <= AN_OFF;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.digit_idx = idx_q;
endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 P_DIGITS, 4, number of multiplexed digits; legal range 1..8.
REQ-002 P_SCAN_DIV, 50000, clock cycles per digit slot; legal range 2..2^20.
REQ-003 P_DEAD, 1, cycles at slot start with all anodes off (anti-ghosting); legal range 0..P_SCAN_DIV-1.
REQ-004 P_AN_ACT_LOW, 1'b1, anode polarity: 1 means a driven-low anode is active, 0 means a driven-high anode is active.
REQ-005 clk  input  1  single clock; all state changes on posedge clk.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 en  input  1  display enable; 0 means blank display and freeze scan.
REQ-008 load  input  1  capture strobe for data/dp/blank.
REQ-009 data  input  4*P_DIGITS  hex nibbles; digit i is data[4i+3:4i], digit 0 is least significant.
REQ-010 dp  input  P_DIGITS  decimal point per digit; 1 means lit.
REQ-011 blank  input  P_DIGITS  per-digit forced blank; 1 means segments off, dp off.
REQ-012 seg  output  8  registered segment bus, active-low; bit7 is dp, bits6:0 are g..a.
REQ-013 an  output  P_DIGITS  registered one-hot anode select, polarity per P_AN_ACT_LOW.
REQ-014 digit_idx  output  max(1,$clog2(P_DIGITS))  index of digit currently scanned.

Function
REQ-015 Hex decode shall be active-low bits6:0 per nibble 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E; seg[7] shall be ~dp of the selected digit.
REQ-016 The prescaler shall count 0..P_SCAN_DIV-1 while en=1, wrap to 0, and hold its value while en=0.
REQ-017 At prescaler terminal count with en=1, digit_idx shall advance by 1 and wrap from P_DIGITS-1 to 0.
REQ-018 When load=1, the shadow registers shall capture data/dp/blank in that cycle; the captured values shall be visible on seg from the next cycle's output update.
REQ-019 seg/an shall be registered with 1-cycle latency from prescaler/index/shadow state.
REQ-020 When prescaler<P_DEAD, an shall be all inactive and seg=8'hFF.
REQ-021 Otherwise, exactly one anode (digit_idx) shall be active.
REQ-022 Otherwise, seg shall be the decode of the selected digit, or 8'hFF when blank[idx]=1.
REQ-023 When en=0, an shall be all inactive and seg=8'hFF from the next cycle; when en returns to 1, scanning shall resume from the held prescaler/index.
REQ-024 When load and terminal count occur in the same cycle, both shall take effect; the new digit shall show the newly captured data.
REQ-025 When P_DIGITS=1, digit_idx shall be constant 0, and an shall pulse inactive only during the dead time.

Reset
REQ-026 rst=1 shall take priority over en/load.
REQ-027 During rst, the prescaler and digit_idx shall be set to 0.
REQ-028 During rst, the shadow data/dp shall be set to 0 and the shadow blank to all-ones.
REQ-029 On the cycle after rst, seg shall be 8'hFF and an shall be all inactive.
REQ-030 Reset mid-slot shall abort the slot; after release, the first active slot shall be digit 0 following P_DEAD cycles.

Configuration
REQ-031 Macro SEG7_SCAN_LZB_EN, when defined, shall enable leading-zero blanking: digit i>0 shall be blanked when it and all higher digits hold nibble 0.
REQ-032 With SEG7_SCAN_LZB_EN defined, digit 0 shall never be LZB-blanked, and the dp of an LZB-blanked digit shall still follow dp[i].
REQ-033 Without SEG7_SCAN_LZB_EN, every non-forced-blank digit shall display its nibble, including leading zeros.

Verification (P_DIGITS=4, P_SCAN_DIV=4, P_DEAD=1, P_AN_ACT_LOW=1)
REQ-034 Reset, then load data=16'h12AF, dp=4'b0000, blank=0 with en=1 -> scanning shall follow an sequence 1110,1101,1011,0111 with seg C0-family values 8E,88,A4,F9; each slot shall be 3 active cycles plus 1 dead cycle with an=1111 and seg=FF.
REQ-035 Same stimulus -> digit_idx shall wrap 3->0, and digit 0 shall reappear 16 cycles after its previous slot start.
REQ-036 Deassert en mid-slot for 10 cycles -> an=1111 and seg=FF shall hold throughout, and the slot shall resume at the held prescaler count.
REQ-037 Load data=16'h0070, dp=4'b0010, no LZB macro -> digit1 seg=78 (dp lit) and digit3 seg=C0; with LZB macro -> digit3 seg=FF, digit2 seg=FF, digit1 seg=78, and digit0 seg=C0.
REQ-038 Assert load with a new value on the terminal-count cycle -> the next digit shall show the new value.
REQ-039 Assert rst mid-slot -> on the next cycle seg=FF, an=1111, and idx=0.
